pc_sequencer: RTL and testbench

- Owns the architectural PC register and sequences the next-PC datapath.
- Each cycle it chooses the NPC operation: sequential, branch, jump or jalr.
- It drives the instruction-memory fetch handshake and raises pipeline flushes on EX-stage redirects.
- It sits in the IF stage, between the hazard unit, the EX stage and the next-PC adder block.

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_sequencer_sat_counter16.sv | 32 +++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared control encodings for the IF-stage PC sequencer: NPC ops, FSM states, reset PC.
package pc_sequencer_pkg;

   localparam int          NPC_OP_W         = 5;
   localparam logic [4:0]  NPC_PLUS4        = 5'b00000;
   localparam logic [4:0]  NPC_BRANCH       = 5'b00001;
   localparam logic [4:0]  NPC_JUMP         = 5'b00010;
   localparam logic [4:0]  NPC_JALR         = 5'b00100;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_e;

   function automatic logic is_redirect_op(input logic [NPC_OP_W-1:0] op);
      return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
   endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter16.sv
// 16-bit up-counter that sticks at all-ones; synchronous clear beats enable.
module sat_counter16 (
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 16'h0000;
      end else if (en_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'h0001;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC owner: picks the NPC op, runs the fetch handshake and flushes on EX redirects.
//  state | meaning
//  BOOT  | first cycle after reset, no fetch request, pc = RESET_PC
//  RUN   | fetching; sequential advance, stall, or redirect
//  HOLD  | redirect taken with fetch outstanding; target latched until ready
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          OP_W     = NPC_OP_W
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            stall_i,
   input  logic            ex_valid_i,
   input  logic [OP_W-1:0] ex_npcop_i,
   input  logic [31:0]     npc_i,
   output logic [OP_W-1:0] npc_op_o,
   output logic [31:0]     pc_o,
   output logic            imem_req_o,
   input  logic            imem_ready_i,
   output logic            fetch_valid_o,
   output logic            flush_ifid_o,
   output logic            flush_idex_o,
   output logic [15:0]     redirect_cnt_o
);

   seq_state_e      state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     tgt_q, tgt_d;
   logic [OP_W-1:0] npc_op;
   logic            req, fetch_valid, flush, cnt_en;
   logic            redirect;
   logic [31:0]     npc_aligned;

   assign redirect    = ex_valid_i && is_redirect_op(ex_npcop_i);
   assign npc_aligned = npc_i & PC_ALIGN_MASK;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      npc_op      = OP_W'(NPC_PLUS4);
      req         = 1'b0;
      fetch_valid = 1'b0;
      flush       = 1'b0;
      cnt_en      = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            req = 1'b1;
            if (redirect) begin
               npc_op = ex_npcop_i;
               flush  = 1'b1;
               cnt_en = 1'b1;
               if (imem_ready_i) begin
                  pc_d = npc_aligned;
               end else begin
                  tgt_d   = npc_aligned;
                  state_d = ST_HOLD;
               end
            end else if (!stall_i) begin
               fetch_valid = imem_ready_i;
               if (imem_ready_i) begin
                  pc_d = npc_aligned;
               end
            end
         end
         ST_HOLD: begin
            // pc stays put until the outstanding fetch completes; its data is dropped
            req = 1'b1;
            if (redirect) begin
               npc_op = ex_npcop_i;
               flush  = 1'b1;
               cnt_en = 1'b1;
               if (imem_ready_i) begin
                  pc_d    = npc_aligned;
                  state_d = ST_RUN;
               end else begin
                  tgt_d = npc_aligned;
               end
            end else if (imem_ready_i) begin
               pc_d    = tgt_q;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   sat_counter16 u_redirect_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .clr_i (1'b0),
      .en_i  (cnt_en),
      .cnt_o (redirect_cnt_o)
   );

   assign npc_op_o      = npc_op;
   assign pc_o          = pc_q;
   assign imem_req_o    = req;
   assign fetch_valid_o = fetch_valid;
   assign flush_ifid_o  = flush;
   assign flush_idex_o  = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall_i;
   logic        ex_valid_i;
   logic [4:0]  ex_npcop_i;
   logic [31:0] npc_i;
   logic [4:0]  npc_op_o;
   logic [31:0] pc_o;
   logic        imem_req_o;
   logic        imem_ready_i;
   logic        fetch_valid_o;
   logic        flush_ifid_o;
   logic        flush_idex_o;
   logic [15:0] redirect_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0000_0000), .OP_W(5)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .stall_i        (stall_i),
      .ex_valid_i     (ex_valid_i),
      .ex_npcop_i     (ex_npcop_i),
      .npc_i          (npc_i),
      .npc_op_o       (npc_op_o),
      .pc_o           (pc_o),
      .imem_req_o     (imem_req_o),
      .imem_ready_i   (imem_ready_i),
      .fetch_valid_o  (fetch_valid_o),
      .flush_ifid_o   (flush_ifid_o),
      .flush_idex_o   (flush_idex_o),
      .redirect_cnt_o (redirect_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stall, input logic exv, input logic [4:0] op,
                        input logic [31:0] npc, input logic rdy);
      stall_i      = stall;
      ex_valid_i   = exv;
      ex_npcop_i   = op;
      npc_i        = npc;
      imem_ready_i = rdy;
      #2;
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] op, input logic flush, input logic fv);
      chk({tag, "_op"},    {27'd0, npc_op_o}, {27'd0, op});
      chk({tag, "_fifid"}, {31'd0, flush_ifid_o}, {31'd0, flush});
      chk({tag, "_fidex"}, {31'd0, flush_idex_o}, {31'd0, flush});
      chk({tag, "_fv"},    {31'd0, fetch_valid_o}, {31'd0, fv});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      stall_i = 1'b0; ex_valid_i = 1'b0; ex_npcop_i = NPC_PLUS4; npc_i = 32'h0; imem_ready_i = 1'b0;
      #3;
      chk("rst_pc",  pc_o, 32'h0);
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_cnt", {16'd0, redirect_cnt_o}, 32'd0);
      chk_ctl("rst", NPC_PLUS4, 1'b0, 1'b0);

      tick();
      rstn = 1'b1;
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h4, 1'b1);
      chk("boot_req", {31'd0, imem_req_o}, 32'd0);
      chk("boot_pc",  pc_o, 32'h0);
      chk("boot_fv",  {31'd0, fetch_valid_o}, 32'd0);
      tick();

      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, NPC_PLUS4, 32'(4 * k + 4), 1'b1);
         chk("seq_pc",  pc_o, 32'(4 * k));
         chk("seq_req", {31'd0, imem_req_o}, 32'd1);
         chk_ctl("seq", NPC_PLUS4, 1'b0, 1'b1);
         tick();
      end

      drive(1'b0, 1'b1, NPC_BRANCH, 32'h40, 1'b1);
      chk("br_pc", pc_o, 32'h10);
      chk_ctl("br", NPC_BRANCH, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h44, 1'b1);
      chk("br_newpc", pc_o, 32'h40);
      chk("br_cnt", {16'd0, redirect_cnt_o}, 32'd1);

      drive(1'b0, 1'b1, NPC_JUMP, 32'h20, 1'b1);
      chk_ctl("jmp", NPC_JUMP, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, NPC_PLUS4, 32'h24, 1'b1);
         chk("stall_pc", pc_o, 32'h20);
         chk_ctl("stall", NPC_PLUS4, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h24, 1'b1);
      chk("unstall_pc", pc_o, 32'h20);
      chk("unstall_fv", {31'd0, fetch_valid_o}, 32'd1);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h28, 1'b1);
      chk("resume_pc", pc_o, 32'h24);
      chk("jmp_cnt", {16'd0, redirect_cnt_o}, 32'd2);

      drive(1'b0, 1'b1, NPC_JALR, 32'h103, 1'b0);
      chk_ctl("jalr", NPC_JALR, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h28, 1'b0);
      chk("hold_pc",  pc_o, 32'h24);
      chk("hold_req", {31'd0, imem_req_o}, 32'd1);
      chk_ctl("hold", NPC_PLUS4, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, NPC_PLUS4, 32'h28, 1'b1);
      chk("hold_rdy_pc", pc_o, 32'h24);
      chk("hold_rdy_fv", {31'd0, fetch_valid_o}, 32'd0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h104, 1'b1);
      chk("jalr_pc",  pc_o, 32'h100);
      chk("jalr_fv",  {31'd0, fetch_valid_o}, 32'd1);
      chk("jalr_cnt", {16'd0, redirect_cnt_o}, 32'd3);
      tick();

      drive(1'b1, 1'b1, NPC_BRANCH, 32'h200, 1'b1);
      chk("rs_pc", pc_o, 32'h104);
      chk_ctl("rs", NPC_BRANCH, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h204, 1'b0);
      chk("rs_newpc", pc_o, 32'h200);
      chk("rs_cnt", {16'd0, redirect_cnt_o}, 32'd4);

      drive(1'b0, 1'b1, NPC_JUMP, 32'h300, 1'b0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h204, 1'b0);
      chk("h2_pc",  pc_o, 32'h200);
      chk("h2_cnt", {16'd0, redirect_cnt_o}, 32'd5);
      rstn = 1'b0;
      #1;
      chk("mid_rst_pc",  pc_o, 32'h0);
      chk("mid_rst_cnt", {16'd0, redirect_cnt_o}, 32'd0);
      chk("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
      tick();
      rstn = 1'b1;
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h4, 1'b1);
      chk("reboot_req", {31'd0, imem_req_o}, 32'd0);
      chk("reboot_pc",  pc_o, 32'h0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h4, 1'b1);
      chk("rerun_req", {31'd0, imem_req_o}, 32'd1);
      chk("rerun_pc",  pc_o, 32'h0);
      tick();
      drive(1'b0, 1'b0, NPC_PLUS4, 32'h8, 1'b1);
      chk("rerun_pc2", pc_o, 32'h4);

      drive(1'b0, 1'b1, NPC_BRANCH, 32'h40, 1'b1);
      repeat (65532) @(posedge clk);
      #3;
      chk("sat_near", {16'd0, redirect_cnt_o}, 32'h0000_FFFC);
      repeat (3) @(posedge clk);
      #3;
      chk("sat_max", {16'd0, redirect_cnt_o}, 32'h0000_FFFF);
      repeat (3) @(posedge clk);
      #3;
      chk("sat_hold", {16'd0, redirect_cnt_o}, 32'h0000_FFFF);
      chk("sat_pc", pc_o, 32'h40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
